// File: rtl/skylark_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package skylark_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_D_STREAK_DEFAULT = 4;
    localparam int unsigned STREAK_W             = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants taken while an instruction fetch waits.
module arb_streak_counter
    import skylark_pkg::*;
#(
    parameter int unsigned MAX = MAX_D_STREAK_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                clr,
    output logic [STREAK_W-1:0] count
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX);

    logic [STREAK_W-1:0] r_count;

    // Streak register: clear wins over increment, increment stops at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {STREAK_W{1'b0}};
        end else if (clr) begin
            r_count <= {STREAK_W{1'b0}};
        end else if (inc && (r_count != LIMIT)) begin
            r_count <= r_count + {{(STREAK_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one shared memory port.
// Data normally wins; a bounded data streak guarantees fetch progress.
module mem_arbiter
    import skylark_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        gnt_d
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                w_streak_inc;
    logic                w_streak_clr;
    logic [STREAK_W-1:0] w_streak;

    arb_streak_counter #(
        .MAX (MAX_D_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_streak_inc),
        .clr   (w_streak_clr),
        .count (w_streak)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and streak bookkeeping; m_ack is only honoured in a grant state.
    always_comb begin
        w_next_state = r_state;
        w_streak_inc = 1'b0;
        w_streak_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && (!i_req || (w_streak != STREAK_LIMIT))) begin
                    w_next_state = GRANT_D;
                    w_streak_inc = i_req;
                    w_streak_clr = !i_req;
                end else if (i_req) begin
                    w_next_state = GRANT_I;
                    w_streak_clr = 1'b1;
                end else begin
                    w_next_state = IDLE;
                    w_streak_clr = 1'b1;
                end
            end
            GRANT_I: begin
                if (m_ack) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GRANT_I;
                end
            end
            GRANT_D: begin
                if (m_ack) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GRANT_D;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory-port launch, completion capture and one-cycle ack pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 32'h0000_0000;
            m_wdata <= 32'h0000_0000;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= 32'h0000_0000;
            d_rdata <= 32'h0000_0000;
            gnt_d   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            gnt_d <= (w_next_state == GRANT_D);
            case (r_state)
                IDLE: begin
                    if (w_next_state == GRANT_D) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (w_next_state == GRANT_I) begin
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= 32'h0000_0000;
                    end
                end
                GRANT_I: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        i_ack   <= 1'b1;
                        i_rdata <= m_rdata;
                    end
                end
                GRANT_D: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        d_ack <= 1'b1;
                        // A store completes with an ack but leaves the last load data visible.
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected results, a negedge
// monitor pops and compares them whenever the DUT acknowledges or completes a transfer.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        gnt_d;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          wt;
        logic [31:0] rdata;
    } plan_t;

    mem_exp_t    exp_mem[$];
    plan_t       plan[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    int   checks   = 0;
    int   errors   = 0;
    logic sb_on    = 1'b1;
    logic late_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .gnt_d   (gnt_d)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d_ack(input string name);
        for (int k = 0; k < 20; k++) begin
            if (d_ack) break;
            cyc();
        end
        chk(name, {63'd0, d_ack}, 64'd1);
    endtask

    // Memory model: each accepted m_req takes the next planned wait count and read data.
    initial begin : responder
        int          cnt;
        logic        active;
        logic [31:0] rd;
        plan_t       p;
        m_ack  = 1'b0;
        m_rdata = 32'h0000_0000;
        active = 1'b0;
        cnt    = 0;
        rd     = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                m_ack  = 1'b0;
                active = 1'b0;
            end else if (active && m_ack) begin
                m_ack  = 1'b0;
                active = 1'b0;
            end else if (active || m_req) begin
                if (!active) begin
                    active = 1'b1;
                    if (plan.size() > 0) begin
                        p   = plan.pop_front();
                        cnt = p.wt;
                        rd  = p.rdata;
                    end else begin
                        cnt = int'($urandom_range(0, 3));
                        rd  = $urandom;
                    end
                end
                if (cnt == 0) begin
                    m_ack   = 1'b1;
                    m_rdata = rd;
                end else begin
                    cnt--;
                end
            end else begin
                m_ack = late_ack;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    initial begin : monitor
        logic        pend_i;
        logic        pend_d;
        logic        prev_req;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic [1:0]  prev_ctl;
        mem_exp_t    e;
        logic [31:0] r;
        pend_i = 1'b0;
        pend_d = 1'b0;
        prev_req = 1'b0;
        prev_addr = 32'h0;
        prev_wdata = 32'h0;
        prev_ctl = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_outputs_zero",
                    {63'd0, |{m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, gnt_d}}, 64'd0);
                pend_i   = 1'b0;
                pend_d   = 1'b0;
                prev_req = 1'b0;
            end else begin
                chk("i_ack_timing", {63'd0, i_ack}, {63'd0, pend_i});
                chk("d_ack_timing", {63'd0, d_ack}, {63'd0, pend_d});
                chk("acks_exclusive", {63'd0, i_ack & d_ack}, 64'd0);
                if (i_ack && sb_on) begin
                    if (exp_i.size() == 0) begin
                        chk("i_ack_expected", 64'd0, 64'd1);
                    end else begin
                        r = exp_i.pop_front();
                        chk("i_rdata", {32'd0, i_rdata}, {32'd0, r});
                    end
                end
                if (d_ack && sb_on) begin
                    if (exp_d.size() == 0) begin
                        chk("d_ack_expected", 64'd0, 64'd1);
                    end else begin
                        r = exp_d.pop_front();
                        chk("d_rdata", {32'd0, d_rdata}, {32'd0, r});
                    end
                end
                if (m_req && prev_req) begin
                    chk("m_addr_stable", {32'd0, m_addr}, {32'd0, prev_addr});
                    chk("m_wdata_stable", {32'd0, m_wdata}, {32'd0, prev_wdata});
                    chk("m_we_gnt_stable", {62'd0, m_we, gnt_d}, {62'd0, prev_ctl});
                end
                if (m_req && m_ack && sb_on) begin
                    if (exp_mem.size() == 0) begin
                        chk("mem_txn_expected", 64'd0, 64'd1);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("grant_owner", {63'd0, gnt_d}, {63'd0, e.is_d});
                        chk("m_addr", {32'd0, m_addr}, {32'd0, e.addr});
                        chk("m_we", {63'd0, m_we}, {63'd0, e.we});
                        if (e.we) begin
                            chk("m_wdata", {32'd0, m_wdata}, {32'd0, e.wdata});
                        end
                    end
                end
                pend_i     = m_req & m_ack & ~gnt_d;
                pend_d     = m_req & m_ack & gnt_d;
                prev_req   = m_req;
                prev_addr  = m_addr;
                prev_wdata = m_wdata;
                prev_ctl   = {m_we, gnt_d};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acks;
        logic is_d;
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt_d", {63'd0, gnt_d}, 64'd0);
        chk("reset_m_req", {63'd0, m_req}, 64'd0);
        reset = 1'b1;
        cyc();
        cyc();

        // Zero-wait instruction fetch.
        plan.push_back('{0, 32'h0050_0093});
        exp_mem.push_back('{1'b0, 32'h0000_0010, 1'b0, 32'h0});
        exp_i.push_back(32'h0050_0093);
        i_addr = 32'h0000_0010;
        i_req  = 1'b1;
        cyc();
        i_req = 1'b0;
        chk("fetch_m_req_c1", {63'd0, m_req}, 64'd1);
        chk("fetch_m_addr_c1", {32'd0, m_addr}, 64'h10);
        chk("fetch_gnt_d_c1", {63'd0, gnt_d}, 64'd0);
        cyc();
        chk("fetch_i_ack_c2", {63'd0, i_ack}, 64'd1);
        chk("fetch_i_rdata_c2", {32'd0, i_rdata}, {32'd0, 32'h0050_0093});
        cyc();
        chk("fetch_i_ack_single", {63'd0, i_ack}, 64'd0);

        // Data load with one wait state, establishing d_rdata.
        plan.push_back('{1, 32'h1234_5678});
        exp_mem.push_back('{1'b1, 32'h0000_0200, 1'b0, 32'h0});
        exp_d.push_back(32'h1234_5678);
        d_addr = 32'h0000_0200;
        d_we   = 1'b0;
        d_req  = 1'b1;
        cyc();
        d_req = 1'b0;
        chk("load_gnt_d", {63'd0, gnt_d}, 64'd1);
        wait_d_ack("load_d_ack");
        cyc();

        // Store with three wait states; inputs change after the grant.
        plan.push_back('{3, 32'hFFFF_FFFF});
        exp_mem.push_back('{1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF});
        exp_d.push_back(32'h1234_5678);
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        cyc();
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0BAD_0000;
        d_wdata = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            chk("store_req_we_noack", {61'd0, m_req, m_we, d_ack}, 64'd6);
            chk("store_addr_hold", {32'd0, m_addr}, 64'h100);
            cyc();
        end
        chk("store_d_ack_c5", {63'd0, d_ack}, 64'd1);
        chk("store_d_rdata_kept", {32'd0, d_rdata}, {32'd0, 32'h1234_5678});
        chk("i_rdata_held", {32'd0, i_rdata}, {32'd0, 32'h0050_0093});
        cyc();

        // Both requesters held: data streak limited to four.
        i_addr = 32'h0000_0040;
        d_addr = 32'h0000_0080;
        d_we   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            is_d = (k != 4) && (k != 9);
            plan.push_back('{0, 32'h0000_1000 + 32'(k)});
            exp_mem.push_back('{is_d, is_d ? 32'h0000_0080 : 32'h0000_0040, 1'b0, 32'h0});
            if (is_d) exp_d.push_back(32'h0000_1000 + 32'(k));
            else      exp_i.push_back(32'h0000_1000 + 32'(k));
        end
        i_req = 1'b1;
        d_req = 1'b1;
        acks  = 0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (i_ack || d_ack) acks++;
            if (acks == 10) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("streak_ack_count", 64'(acks), 64'd10);
        cyc();
        cyc();

        // Reset during a data wait abandons the transfer; a late m_ack is ignored.
        plan.push_back('{5, 32'h5555_5555});
        d_addr = 32'h0000_0300;
        d_req  = 1'b1;
        cyc();
        d_req = 1'b0;
        cyc();
        cyc();
        chk("abort_in_grant_d", {62'd0, gnt_d, m_req}, 64'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {63'd0, |{m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, gnt_d}}, 64'd0);
        cyc();
        cyc();
        reset    = 1'b1;
        late_ack = 1'b1;
        cyc();
        cyc();
        late_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_ack_ignored", {61'd0, i_ack, d_ack, m_req}, 64'd0);
            cyc();
        end

        // Requester drops d_req one cycle after the grant; the ack still arrives.
        plan.push_back('{2, 32'hCAFE_0001});
        exp_mem.push_back('{1'b1, 32'h0000_0400, 1'b0, 32'h0});
        exp_d.push_back(32'hCAFE_0001);
        d_addr = 32'h0000_0400;
        d_req  = 1'b1;
        cyc();
        cyc();
        d_req = 1'b0;
        cyc();
        chk("drop_m_ack_c3", {62'd0, m_req, m_ack}, 64'd3);
        cyc();
        chk("drop_d_ack_c4", {63'd0, d_ack}, 64'd1);
        chk("drop_d_rdata", {32'd0, d_rdata}, {32'd0, 32'hCAFE_0001});
        cyc();

        // Random mixed traffic: protocol checks stay active, scoreboard paused.
        sb_on = 1'b0;
        for (int k = 0; k < 60; k++) begin
            i_req   = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            cyc();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!m_req) break;
            cyc();
        end
        chk("random_drained", {63'd0, m_req}, 64'd0);
        cyc();
        cyc();
        sb_on = 1'b1;

        chk("exp_mem_empty", 64'(exp_mem.size()), 64'd0);
        chk("exp_i_empty", 64'(exp_i.size()), 64'd0);
        chk("exp_d_empty", 64'(exp_d.size()), 64'd0);
        chk("plan_empty", 64'(plan.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, meaning the maximum consecutive data grants while an instruction request waits (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req  input  1  fetch request; i_addr  input  32  fetch address.
REQ-005 SHALL have ports i_ack  output  1  one-cycle fetch completion pulse; i_rdata  output  32  fetched instruction.
REQ-006 SHALL have ports d_req  input  1  data request; d_we  input  1  write when high, read when low; d_addr  input  32  data address; d_wdata  input  32  store data.
REQ-007 SHALL have ports d_ack  output  1  one-cycle data completion pulse; d_rdata  output  32  load data.
REQ-008 SHALL have ports m_req  output  1; m_we  output  1; m_addr  output  32; m_wdata  output  32; m_rdata  input  32; m_ack  input  1, forming a single shared memory port with a variable number of wait states.
REQ-009 SHALL have port gnt_d  output  1  high while the data requester owns the memory port, for hazard-unit stall generation.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-011 In IDLE, a cycle with only i_req high SHALL transition to GRANT_I, and a cycle with only d_req high SHALL transition to GRANT_D.
REQ-012 In IDLE with both requests high, data SHALL win unless d_streak equals MAX_D_STREAK, in which case instruction SHALL win.
REQ-013 On the granting edge, the arbiter SHALL register the winner's address, we and wdata into m_addr, m_we and m_wdata, and SHALL set m_req high.
REQ-014 m_req, m_addr, m_we and m_wdata SHALL remain stable until the cycle in which m_ack is sampled high.
REQ-015 On the m_ack cycle in GRANT_x, the arbiter SHALL register m_rdata into x_rdata, pulse x_ack high for exactly the next cycle, drop m_req, and return to IDLE.
REQ-016 Minimum latency SHALL be: request in IDLE at cycle 0, m_req at cycle 1, m_ack at cycle 1, x_ack and x_rdata valid at cycle 2; each wait state adds one cycle.
REQ-017 There SHALL be one IDLE bubble between consecutive transactions.
REQ-018 On a write (m_we=1), d_ack SHALL still pulse and d_rdata SHALL retain its previous value.
REQ-019 x_rdata SHALL hold its value until the next completed read for that requester.
REQ-020 d_streak (4 bits) SHALL increment on each GRANT_D entry while i_req is high, SHALL saturate at MAX_D_STREAK, and SHALL clear on every GRANT_I entry or on any IDLE cycle with i_req low.
REQ-021 If a requester drops its req mid-transaction, the memory transaction SHALL complete and the ack SHALL still pulse; no abort exists.
REQ-022 m_ack sampled in IDLE SHALL be ignored.
REQ-023 gnt_d SHALL equal (state == GRANT_D).
REQ-024 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-025 While reset is low, state SHALL be IDLE, d_streak SHALL be 0, and every output (m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, gnt_d) SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-transaction SHALL abandon that transaction with no ack; a late m_ack after release SHALL be ignored per REQ-022.

Structure
REQ-027 Shared package skylark_pkg SHALL hold the arb_state_t enum (IDLE, GRANT_I, GRANT_D) and the default for MAX_D_STREAK.
REQ-028 The streak counter SHALL be a sub-module named arb_streak_counter (inputs inc, clr; output count; saturating); all other logic SHALL be inline.

Verification
REQ-029 Scenario: i_req with i_addr=0x0000_0010, m_ack with zero wait, m_rdata=0x0050_0093 -> m_addr=0x10 at cycle 1, i_ack and i_rdata=0x0050_0093 at cycle 2.
REQ-030 Scenario: d_req write with d_addr=0x100, d_wdata=0xDEAD_BEEF, 3 wait states -> m_we=1 and address/data stable for 4 cycles, d_ack at cycle 5, d_rdata unchanged.
REQ-031 Scenario: i_req and d_req held continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 Scenario: reset pulled low during GRANT_D wait -> all outputs 0 immediately; m_ack after release produces no ack.
REQ-033 Scenario: d_req dropped one cycle after grant -> d_ack still pulses on m_ack+1, and i_ack/d_ack are never coincident throughout random traffic.
